// File: rtl/ex_flag_unit.sv
// ----------------------------------------------------------------------------
// ex_flag_unit
//
// Execute-stage flag register and branch-condition unit. Sits directly after
// the adder (CLA_16b) and the ALU result mux.
//   - Latches the ALU result into the EX/MEM boundary register.
//   - Updates the architectural FLAG register {Z,V,N} for flag-writing opcodes.
//   - Evaluates the branch condition of a branch in EX against the flags that
//     were committed before this cycle.
// It accepts one instruction per cycle. The hazard unit drives stall and flush.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   asynchronous, active-high reset
//   stall        in   hold all registers; no flag update
//   flush        in   kill the instruction in EX (wins over stall)
//   valid_in     in   EX holds a real instruction
//   opcode[3:0]  in   EX opcode
//   alu_result   in   ALU output (WIDTH bits)
//   alu_flag[2:0]in   adder flags: [2]=Z, [1]=V, [0]=N
//   cond[2:0]    in   branch condition field
//   take_branch  out  combinational: redirect the PC this cycle
//   flag_q[2:0]  out  committed FLAG register {Z,V,N}
//   result_q     out  registered result to MEM
//   valid_q      out  registered valid to MEM (the EMPTY/VALID state)
//   br_taken_q   out  registered take_branch, for MEM and debug
//
// Handshake: the unit has no backpressure of its own. An instruction presented
// with valid_in is consumed at the next rising edge unless stall is high.
// While stall is high every register holds, including flag_q. A flush kills
// the EX instruction regardless of stall: it commits no flags, it clears
// valid_q and br_taken_q, and it leaves result_q unchanged.
// ----------------------------------------------------------------------------
module ex_flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flag,
  input  logic [2:0]       cond,
  output logic             take_branch,
  output logic [2:0]       flag_q,
  output logic [WIDTH-1:0] result_q,
  output logic             valid_q,
  output logic             br_taken_q
);

  // Opcode encodings
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;

  // Branch condition encodings
  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_AL   = 3'b111;

  // EX/MEM entry state. valid_q is a direct decode of this state.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } entry_state_e;

  entry_state_e state_q;
  entry_state_e state_d;

  logic [2:0]       flag_d;
  logic [WIDTH-1:0] result_d;
  logic             br_taken_d;

  logic commit;
  logic is_arith;
  logic is_zonly;
  logic is_branch;
  logic res_zero;
  logic cond_met;
  logic z_f;
  logic v_f;
  logic n_f;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign commit    = valid_in & ~stall & ~flush;
  assign is_arith  = (opcode == OP_ADD) | (opcode == OP_SUB);
  assign is_zonly  = (opcode == OP_XOR) | (opcode == OP_SLL) |
                     (opcode == OP_SRA) | (opcode == OP_ROR);
  assign is_branch = valid_in & ((opcode == OP_B) | (opcode == OP_BR));

  // Logic and shift ops derive Z from the whole result. The adder's flags
  // are not meaningful for them.
  assign res_zero = (alu_result == '0);

  // --------------------------------------------------------------------------
  // Branch condition, evaluated on the flags committed before this cycle.
  // There is no forwarding path. A flag writer in the previous cycle has
  // already updated flag_q at the edge that ended its EX cycle.
  // --------------------------------------------------------------------------
  assign z_f = flag_q[2];
  assign v_f = flag_q[1];
  assign n_f = flag_q[0];

  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      CC_NE:   cond_met = ~z_f;
      CC_EQ:   cond_met = z_f;
      CC_GT:   cond_met = ~z_f & ~n_f;
      CC_LT:   cond_met = n_f;
      CC_GTE:  cond_met = z_f | ~n_f;
      CC_LTE:  cond_met = z_f | n_f;
      CC_OVFL: cond_met = v_f;
      CC_AL:   cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // A stalled or flushed branch does not redirect. A stalled branch is
  // re-evaluated when the stall releases; flag_q cannot change meanwhile.
  assign take_branch = is_branch & cond_met & ~flush & ~stall;

  // --------------------------------------------------------------------------
  // Next-state: FLAG register
  // --------------------------------------------------------------------------
  always_comb begin
    flag_d = flag_q;
    if (commit) begin
      if (is_arith) begin
        flag_d = alu_flag;
      end else if (is_zonly) begin
        // Only Z is written. V and N keep their committed values.
        flag_d = {res_zero, flag_q[1:0]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: EX/MEM pipeline register and entry state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    br_taken_d = br_taken_q;
    if (flush) begin
      // A flush kills the entry but leaves result_q as it was.
      state_d    = ST_EMPTY;
      br_taken_d = 1'b0;
    end else if (!stall) begin
      state_d    = valid_in ? ST_VALID : ST_EMPTY;
      result_d   = alu_result;
      br_taken_d = take_branch;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      flag_q     <= 3'b000;
      result_q   <= '0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      result_q   <= result_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign valid_q = (state_q == ST_VALID);

endmodule

// File: tb/tb_ex_flag_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_flag_unit
//
// Directed bench for ex_flag_unit. Each step drives one EX cycle. It checks
// take_branch combinationally before the rising edge, then checks the
// registered outputs 1 ns after that edge. Every expected value below was
// worked out by hand from the flag and condition rules.
// ----------------------------------------------------------------------------
module tb_ex_flag_unit;

  localparam int WIDTH = 16;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] NOP = 4'b0010;
  localparam logic [3:0] XOR = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100;
  localparam logic [3:0] SRA = 4'b0101;
  localparam logic [3:0] ROR = 4'b0110;
  localparam logic [3:0] B   = 4'b1100;
  localparam logic [3:0] BR  = 4'b1101;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flush;
  logic             valid_in;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       alu_flag;
  logic [2:0]       cond;
  logic             take_branch;
  logic [2:0]       flag_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             br_taken_q;

  int tests_run;
  int tests_failed;

  ex_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .valid_in    (valid_in),
    .opcode      (opcode),
    .alu_result  (alu_result),
    .alu_flag    (alu_flag),
    .cond        (cond),
    .take_branch (take_branch),
    .flag_q      (flag_q),
    .result_q    (result_q),
    .valid_q     (valid_q),
    .br_taken_q  (br_taken_q)
  );

  // Clock: posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one EX cycle's inputs, then let them settle.
  task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] res,
                       input logic [2:0] flg, input logic [2:0] cc,
                       input logic vin, input logic stl, input logic fls);
    opcode     = op;
    alu_result = res;
    alu_flag   = flg;
    cond       = cc;
    valid_in   = vin;
    stall      = stl;
    flush      = fls;
    #1;
  endtask

  // Advance past the next rising edge, to a point where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all registered outputs at once.
  task automatic chk_regs(input string tag, input logic [2:0] e_flag,
                          input logic [WIDTH-1:0] e_res, input logic e_valid,
                          input logic e_br);
    chk({tag, ".flag_q"},     32'(flag_q),     32'(e_flag));
    chk({tag, ".result_q"},   32'(result_q),   32'(e_res));
    chk({tag, ".valid_q"},    32'(valid_q),    32'(e_valid));
    chk({tag, ".br_taken_q"}, 32'(br_taken_q), 32'(e_br));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    valid_in   = 1'b0;
    opcode     = NOP;
    alu_result = '0;
    alu_flag   = 3'b000;
    cond       = 3'b000;

    // ---- reset state ----
    #2;
    chk_regs("reset", 3'b000, 16'h0000, 1'b0, 1'b0);
    chk("reset.take_branch", 32'(take_branch), 32'd0);
    tick();
    rst = 1'b0;

    // ---- ADD 7FFF+0010: overflow and negative ----
    drive(ADD, 16'h800F, 3'b011, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("add1.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("add1", 3'b011, 16'h800F, 1'b1, 1'b0);

    // ---- B OVFL sees V=1 immediately ----
    drive(B, 16'h0000, 3'b000, 3'b110, 1'b1, 1'b0, 1'b0);
    chk("b_ovfl.take_branch", 32'(take_branch), 32'd1);
    tick();
    chk_regs("b_ovfl", 3'b011, 16'h0000, 1'b1, 1'b1);

    // ---- ADD 800A+80FF: overflow, positive result ----
    drive(ADD, 16'h0109, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("add2", 3'b010, 16'h0109, 1'b1, 1'b0);

    // ---- B LT (N=0) not taken; BR GTE taken ----
    drive(B, 16'h0000, 3'b000, 3'b011, 1'b1, 1'b0, 1'b0);
    chk("b_lt.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("b_lt", 3'b010, 16'h0000, 1'b1, 1'b0);
    drive(BR, 16'h0000, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0);
    chk("br_gte.take_branch", 32'(take_branch), 32'd1);
    tick();
    chk("br_gte.br_taken_q", 32'(br_taken_q), 32'd1);

    // ---- branch-shaped opcode with valid_in=0 never redirects ----
    drive(B, 16'h0000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
    chk("b_invalid.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("b_invalid", 3'b010, 16'h0000, 1'b0, 1'b0);

    // ---- set flags 011, then XOR zero result: Z set, V/N held ----
    drive(ADD, 16'h8001, 3'b011, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add3.flag_q", 32'(flag_q), 32'b011);
    drive(XOR, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("xor_zero", 3'b111, 16'h0000, 1'b1, 1'b0);
    drive(SLL, 16'h0004, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("sll", 3'b011, 16'h0004, 1'b1, 1'b0);

    // ---- Z uses the full width: 8000 is non-zero, ROR 0 is zero ----
    drive(SRA, 16'h8000, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sra_msb.flag_q", 32'(flag_q), 32'b011);
    drive(ROR, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ror_zero.flag_q", 32'(flag_q), 32'b111);

    // ---- non-flag opcode and an uncommitted ADD both leave flags alone ----
    drive(NOP, 16'h00AA, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("nop", 3'b111, 16'h00AA, 1'b1, 1'b0);
    drive(ADD, 16'h00BB, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_regs("add_invalid", 3'b111, 16'h00BB, 1'b0, 1'b0);

    // ---- restore a known base: flags 011, result 0004, VALID ----
    drive(SLL, 16'h0004, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("sll2", 3'b011, 16'h0004, 1'b1, 1'b0);

    // ---- SUB held by a 2-cycle stall ----
    drive(SUB, 16'h1234, 3'b100, 3'b000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_regs("sub_stall1", 3'b011, 16'h0004, 1'b1, 1'b0);
    tick();
    chk_regs("sub_stall2", 3'b011, 16'h0004, 1'b1, 1'b0);
    drive(SUB, 16'h1234, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("sub_release", 3'b100, 16'h1234, 1'b1, 1'b0);

    // ---- stalled B EQ holds 0, then is taken on release ----
    drive(B, 16'h0000, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
    chk("b_eq_stall.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("b_eq_stall", 3'b100, 16'h1234, 1'b1, 1'b0);
    drive(B, 16'h0000, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("b_eq.take_branch", 32'(take_branch), 32'd1);
    tick();
    chk_regs("b_eq", 3'b100, 16'h0000, 1'b1, 1'b1);

    // ---- ADD with flush+stall: killed, flags and result held ----
    drive(ADD, 16'h5555, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
    tick();
    chk_regs("add_flush", 3'b100, 16'h0000, 1'b0, 1'b0);

    // ---- B always with flush: no redirect ----
    drive(B, 16'h6666, 3'b000, 3'b111, 1'b1, 1'b0, 1'b1);
    chk("b_flush.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("b_flush", 3'b100, 16'h0000, 1'b0, 1'b0);

    // ---- B LTE (Z=1) taken, then flags 111 with VALID entry ----
    drive(BR, 16'h0007, 3'b000, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("br_lte.take_branch", 32'(take_branch), 32'd1);
    tick();
    chk_regs("br_lte", 3'b100, 16'h0007, 1'b1, 1'b1);
    drive(ADD, 16'h0000, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("b_ne_z.pre_add", 32'(take_branch), 32'd0);
    tick();
    chk_regs("add_111", 3'b111, 16'h0000, 1'b1, 1'b0);
    drive(B, 16'h0009, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("b_ne.take_branch", 32'(take_branch), 32'd0);
    tick();
    chk_regs("b_ne", 3'b111, 16'h0009, 1'b1, 1'b0);

    // ---- asynchronous reset mid-cycle ----
    drive(ADD, 16'hBEEF, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_regs("pre_rst", 3'b111, 16'hBEEF, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 3'b000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(B, 16'h0000, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("post_rst_gt.take_branch", 32'(take_branch), 32'd1);
    tick();
    chk_regs("post_rst_gt", 3'b000, 16'h0000, 1'b1, 1'b1);

    drive(NOP, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_regs("drain", 3'b000, 16'h0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_flag_unit.md
# ex_flag_unit

Execute-stage flag register and branch-condition unit that sits directly downstream of `CLA_16b` and the ALU result mux. It latches the 16-bit ALU result and the `{Z,V,N}` flags from `CLA_16b` into an EX/MEM boundary register. It updates the architectural FLAG register only for flag-writing opcodes. It evaluates the 3-bit branch condition of a branch in EX against the committed flags. It is fully pipelined: one instruction per cycle, with stall and flush control from the hazard unit.

## Interface
- `WIDTH`, 16, datapath width of result
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold all registers; no flag update
- `flush`  in  1  kill the instruction in EX; takes priority over `stall`
- `valid_in`  in  1  EX holds a real instruction
- `opcode`  in  4  EX opcode
- `alu_result`  in  WIDTH  ALU output, incl. `CLA_16b.S` for ADD/SUB
- `alu_flag`  in  3  `CLA_16b.flag`: [2]=Z, [1]=V, [0]=N
- `cond`  in  3  branch condition field
- `take_branch`  out  1  combinational: redirect PC this cycle
- `flag_q`  out  3  committed FLAG register {Z,V,N}
- `result_q`  out  WIDTH  registered result to MEM
- `valid_q`  out  1  registered valid to MEM
- `br_taken_q`  out  1  registered `take_branch`, for MEM/debug

## Operation
- Opcode encodings: ADD 0000, SUB 0001, XOR 0011, SLL 0100, SRA 0101, ROR 0110, B 1100, BR 1101.
- Commit condition: `commit = valid_in & ~stall & ~flush`.
- Flag update, only when `commit`:
  - ADD/SUB: `flag_q <= alu_flag`, all three bits.
  - XOR/SLL/SRA/ROR: Z only. Z is computed internally as `alu_result == 0`, and `alu_flag` is ignored. V and N hold.
  - All other opcodes: `flag_q` holds.
- Branch in EX means `valid_in & (opcode==B | opcode==BR)`.
- Branch condition is evaluated on `flag_q`, the flags committed before this cycle:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | N=0
  - 101 LTE: Z=1 | N=1
  - 110 OVFL: V=1
  - 111 always
- `take_branch` = branch in EX & condition met & ~flush & ~stall.
- The unit has no flag forwarding path. A flag-writing instruction commits at the edge ending its EX cycle, so an immediately following branch sees the new flags.
- Pipeline register:
  - on `flush`: `valid_q <= 0`, `br_taken_q <= 0`, `result_q` holds.
  - else on `stall`: everything holds.
  - else: `result_q <= alu_result`, `valid_q <= valid_in`, `br_taken_q <= take_branch`.
- Two-state FSM per entry (EMPTY/VALID), encoded in `valid_q`:
  - EMPTY→VALID on a cycle with `valid_in` and no `stall`/`flush`.
  - VALID→EMPTY on `flush`, or on a non-stalled cycle with `valid_in=0`.

## Timing
- Reset (async, immediate): `flag_q=3'b000`, `result_q=0`, `valid_q=0`, `br_taken_q=0`. `take_branch` then follows its combinational definition.
- Latency:
  - `result_q`, `valid_q`, `flag_q`, `br_taken_q`: 1 cycle.
  - `take_branch`: 0 cycles, combinational from `flag_q`, `opcode`, `cond` and controls.
- `stall` and `flush` in the same cycle: flush behaviour applies.
- `rst` asserted mid-stream: all state clears in the same cycle. The first post-reset branch evaluates against flags 000, so NE/GT/GTE are taken.
- A stalled branch holds `take_branch=0`. It is re-evaluated against the same `flag_q` when the stall releases, because nothing committed in between.
- Width rule: WIDTH only affects `result_q`. The Z computation for Z-only ops uses the full WIDTH.

## Test plan
- Reset, then ADD with `alu_result=16'h800F`, `alu_flag=3'b011` (from 7FFF+0010) → next cycle `flag_q=011`, `result_q=800F`, `valid_q=1`. Follow with B cond=110 → `take_branch=1`, `br_taken_q=1` one cycle later.
- ADD with `alu_result=16'h0109`, `alu_flag=3'b010` (from 800A+80FF) → `flag_q=010`. Then B cond=011 (LT) → `take_branch=0`; B cond=100 (GTE) → `take_branch=1`.
- Starting from `flag_q=011`, XOR with `alu_result=0`, `alu_flag=3'b000` → `flag_q=111` (Z set internally, V/N held). Then SLL with result 0x0004 → `flag_q=011`.
- SUB with `alu_flag=100` while `stall=1` for 2 cycles → `flag_q` and `result_q` unchanged. On release → `flag_q=100`; B cond=001 (EQ) → taken.
- ADD with `flush=1` and `stall=1` → `valid_q=0`, `flag_q` unchanged, `take_branch=0` for a concurrent branch.
- `rst` pulsed asynchronously mid-cycle while `valid_q=1`, `flag_q=111` → all outputs clear before the next edge. B cond=010 (GT) → `take_branch=1`.
